data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU data-memory interface. It holds the data RAM behind the CPU's `d_addr_bus` / `signal_read_D_mem` / `signal_write_D_mem` / `DATA_BUS` port. It accepts one read or write per 4-phase handshake, inserts a programmable number of wait states, and drives read data onto the shared tristate bus only while it owns it. It sits on the memory side of the CPU, clocked by the CPU's memory-phase clock.

## Interface
Parameters:
- `DEPTH`, 256: number of 16-bit words. Valid range 1..256.
- `WAIT_STATES`, 0: extra cycles between request accept and response. Valid range 0..15.

Ports:
- `clk`  in  1  memory clock. All state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  8  word address, from CPU `d_addr_bus`.
- `rd`  in  1  read request level, from `signal_read_D_mem`.
- `wr`  in  1  write request level, from `signal_write_D_mem`.
- `data_bus`  inout  16  shared data bus. Driven only when `drive_en`; otherwise high-Z.
- `ready`  out  1  response strobe. High for exactly one cycle per accepted request.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on a protocol or address error.

## Operation
- States: IDLE, WAIT, RESP, HOLD.
- **IDLE.** On a clock edge with `rd|wr`=1:
  - Latch `addr`, the operation type, and `data_bus` (write data).
  - Go to WAIT with `cnt`=WAIT_STATES-1 if WAIT_STATES>0; otherwise go to RESP.
- **Both `rd` and `wr` high at accept.**
  - The write takes priority and is performed.
  - `err` pulses in the cycle after the accept edge.
- **WAIT.**
  - `cnt` decrements each edge. The edge where `cnt`=0 moves to RESP.
  - If `rd|wr` is sampled 0 in WAIT, the request is aborted: no write is committed, `ready` stays 0, next state is IDLE.
  - `addr` and `data_bus` changes during WAIT are ignored; only the latched values are used.
- **Commit on the edge that enters RESP.**
  - Write: `mem[addr_q]` <= `wdata_q`.
  - Read: `rdata_q` <= `mem[addr_q]`.
- **Out-of-range address** (`addr_q` >= DEPTH):
  - Write is dropped; read returns 16'h0000.
  - `err` pulses during RESP.
- **RESP** (one cycle):
  - `ready`=1.
  - For a read, `drive_en`=1 and `data_bus`=`rdata_q`.
  - Next state is HOLD if `rd|wr`=1, else IDLE.
- **HOLD.**
  - Waits for `rd`=0 and `wr`=0, then goes to IDLE. No new request is accepted until then.
  - For a read, `data_bus` stays driven with `rdata_q` while `rd`=1; it is released the cycle after `rd` falls.
- **Drive rules.** The block never drives `data_bus` for a write, and never in IDLE or WAIT. `drive_en` is a registered decode of the state, so there is no combinational glitch from `rd`.
- **Memory contents.** The RAM is not cleared by reset. Contents are undefined until written.

## Timing
- **Reset values.** Asserting `reset` at any time forces:
  - state=IDLE, `cnt`=0
  - `ready`=0, `busy`=0, `err`=0
  - `data_bus`=Z
  
  A read in flight is abandoned and a write not yet committed is lost. A write already committed remains.
- **Release from reset.** The first request can be accepted on the first edge after `reset` deasserts.
- **Latency, accept edge E0 to `ready`.** `ready` is high in the cycle following edge E0+WAIT_STATES.
  - WAIT_STATES=0: `ready` is high in the cycle right after E0.
  - WAIT_STATES=3: `ready` is high after E3.
- **Throughput.** Minimum request period is WAIT_STATES+2 cycles (accept, RESP, request low for one edge in IDLE or HOLD).
- **Write visibility.** Read data reflects every write committed before the read's commit edge. Back-to-back write then read of the same address returns the new data.
- **Outputs.** `busy`, `ready` and `err` are registered.

## Test plan
- **Reset.** Assert `reset` mid-WAIT (WAIT_STATES=2) -> `busy`=0, `ready`=0 and `data_bus`=Z immediately; a new read after release completes normally.
- **Write/read, WAIT_STATES=0.** Write 16'hBEEF at addr 8'h12, drop `wr`, then read 8'h12 -> `ready` one cycle after each accept; `data_bus`=16'hBEEF during RESP and HOLD; Z one cycle after `rd` falls.
- **Wait states.** WAIT_STATES=3, read 8'h00 -> `ready` in the cycle after the 4th edge; `busy` high for 4 cycles plus HOLD; `ready` pulses exactly once even with `rd` held high 10 cycles.
- **Abort.** WAIT_STATES=2, write 16'h1234 at 8'h05, drop `wr` after 1 cycle -> no `ready`; subsequent read of 8'h05 returns the previous value.
- **Protocol/range errors.** `rd`=`wr`=1 with addr 8'h07 and data 16'h00AA -> write performed and `err` pulses. With DEPTH=128, read 8'h90 -> `data_bus`=16'h0000, `err` pulse in RESP, `ready` still asserted.
- **Bus contention.** Check across the full randomized handshake sequence that `data_bus` is never driven by the block during write transactions or IDLE.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-RAM responder on the CPU data-memory port.
// One read or write per 4-phase handshake, WAIT_STATES programmable wait
// cycles, read data driven onto the shared bus only in RESP/HOLD.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic       rd,
  input  logic       wr,
  inout  wire [15:0] data_bus,
  output logic       ready,
  output logic       busy,
  output logic       err
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic        op_wr_q;
  logic        ready_q, busy_q, err_q, drive_q;

  logic        req, accept, commit, cur_wr, cur_oor, drive_d;
  logic [7:0]  cur_addr;
  logic [15:0] cur_wdata;

  logic [15:0] mem [DEPTH];

  // Next state; with zero wait states the commit happens on the accept edge,
  // so the live inputs stand in for the not-yet-latched request.
  always_comb begin
    req       = rd | wr;
    accept    = (state_q == S_IDLE) && req;
    cur_addr  = accept ? addr     : addr_q;
    cur_wr    = accept ? wr       : op_wr_q;
    cur_wdata = accept ? data_bus : wdata_q;
    cur_oor   = {1'b0, cur_addr} >= 9'(DEPTH);
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = req ? S_HOLD : S_IDLE;
      S_HOLD:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    commit  = (state_d == S_RESP) && !reset;
    // Read data stays on the bus through HOLD only while rd is still high.
    drive_d = !cur_wr && ((state_d == S_RESP) || ((state_d == S_HOLD) && rd));
  end

  // State, request latch, read capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'd0;
      wdata_q <= 16'd0;
      op_wr_q <= 1'b0;
      rdata_q <= 16'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        op_wr_q <= wr;
        wdata_q <= data_bus;
      end
      if (commit && !cur_wr)
        rdata_q <= cur_oor ? 16'h0000 : mem[cur_addr[AW-1:0]];
      ready_q <= (state_d == S_RESP);
      busy_q  <= (state_d != S_IDLE);
      err_q   <= (accept && rd && wr) || (commit && cur_oor);
      drive_q <= drive_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && cur_wr && !cur_oor)
      mem[cur_addr[AW-1:0]] <= cur_wdata;
  end

  assign data_bus = drive_q ? rdata_q : 16'hzzzz;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders (WS=0/D256, WS=2/D256, WS=3/D128)
// share one handshake stream; a transaction-level model predicts each output.
module tb_data_mem_responder;

  localparam int N       = 3;
  localparam int OP_RD   = 0;
  localparam int OP_WR   = 1;
  localparam int OP_BOTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        rd, wr;
  logic [15:0] tdata;
  logic        tdrv;
  wire  [15:0] bus0, bus1, bus2;
  wire  [N-1:0] busz;
  logic [N-1:0] ready_w, busy_w, err_w;

  assign bus0 = tdrv ? tdata : 16'hzzzz;
  assign bus1 = tdrv ? tdata : 16'hzzzz;
  assign bus2 = tdrv ? tdata : 16'hzzzz;
  assign busz[0] = (bus0 === 16'hzzzz);
  assign busz[1] = (bus1 === 16'hzzzz);
  assign busz[2] = (bus2 === 16'hzzzz);

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .data_bus(bus0),
    .ready(ready_w[0]), .busy(busy_w[0]), .err(err_w[0]));
  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .data_bus(bus1),
    .ready(ready_w[1]), .busy(busy_w[1]), .err(err_w[1]));
  data_mem_responder #(.DEPTH(128), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .data_bus(bus2),
    .ready(ready_w[2]), .busy(busy_w[2]), .err(err_w[2]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [15:0] mmem [N][256];
  bit          mval [N][256];
  bit          chk_en = 1'b0;
  int          cur_c = -1;
  bit          exp_busy [N], exp_ready [N], exp_err [N], exp_drv [N], exp_known [N];
  logic [15:0] exp_val [N];

  // per-transaction observations, used by the literal checks
  int          ready_cnt [N], ready_cyc [N], err_cnt [N];
  logic [15:0] last_rd [N];

  logic [7:0]  pool [8];

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int dep_of(input int k);
    return (k == 2) ? 128 : 256;
  endfunction

  function automatic logic [15:0] busv(input int k);
    case (k)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic set_idle();
    for (int k = 0; k < N; k++) begin
      exp_busy[k] = 0; exp_ready[k] = 0; exp_err[k] = 0; exp_drv[k] = 0;
    end
    cur_c = -1;
  endtask

  // Every cycle: DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        if (cur_c == 0) begin
          ready_cnt[k] = 0; err_cnt[k] = 0; ready_cyc[k] = -1;
        end
        if (ready_w[k]) begin
          ready_cnt[k]++;
          ready_cyc[k] = cur_c;
          if (exp_drv[k]) last_rd[k] = busv(k);
        end
        if (err_w[k]) err_cnt[k]++;
        check($sformatf("busy%0d c%0d", k, cur_c), busy_w[k], exp_busy[k]);
        check($sformatf("ready%0d c%0d", k, cur_c), ready_w[k], exp_ready[k]);
        check($sformatf("err%0d c%0d", k, cur_c), err_w[k], exp_err[k]);
        if (tdrv)
          check($sformatf("bus_wr%0d", k), busv(k), tdata);
        else if (exp_drv[k] && exp_known[k])
          check($sformatf("bus_rd%0d c%0d", k, cur_c), busv(k), exp_val[k]);
        else if (exp_drv[k])
          check($sformatf("bus_drv%0d c%0d", k, cur_c), busz[k], 0);
        else
          check($sformatf("bus_z%0d c%0d", k, cur_c), busz[k], 1);
      end
    end
  end

  // One handshake: request held for h accept-relative edges, then low for g.
  // A DUT completes iff the request is still high on its last wait edge.
  task automatic run_txn(input int op, input logic [7:0] a, input logic [15:0] d,
                         input int h, input int g);
    bit comp [N];
    bit oor [N];
    bit isw;
    int ws;
    isw  = (op != OP_RD);
    rd   = (op != OP_WR);
    wr   = isw;
    addr = a;
    tdata = d;
    tdrv = isw;
    for (int k = 0; k < N; k++) begin
      comp[k] = (h >= ws_of(k) + 1);
      oor[k]  = (int'(a) >= dep_of(k));
    end
    for (int c = 0; c < h + g; c++) begin
      @(posedge clk); #1;
      if (c == h - 1) begin
        rd = 0; wr = 0; tdrv = 0;
      end else if (c < h - 1) begin
        addr  = 8'($urandom);
        tdata = 16'($urandom);
      end
      cur_c = c;
      for (int k = 0; k < N; k++) begin
        ws = ws_of(k);
        exp_busy[k]  = (c < h);
        exp_ready[k] = comp[k] && (c == ws);
        exp_err[k]   = (c == 0 && op == OP_BOTH) || (comp[k] && c == ws && oor[k]);
        exp_drv[k]   = !isw && comp[k] && (c >= ws) && (c < h);
        if (comp[k] && c == ws) begin
          if (isw) begin
            if (!oor[k]) begin
              mmem[k][a] = d;
              mval[k][a] = 1;
            end
          end else begin
            exp_known[k] = oor[k] || mval[k][a];
            exp_val[k]   = oor[k] ? 16'h0000 : mmem[k][a];
          end
        end
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pool = '{8'h00, 8'h05, 8'h07, 8'h12, 8'h7F, 8'h80, 8'h90, 8'hFF};
    for (int k = 0; k < N; k++) begin
      exp_known[k] = 0; exp_val[k] = 16'h0; last_rd[k] = 16'h0;
      ready_cnt[k] = 0; ready_cyc[k] = -1; err_cnt[k] = 0;
      for (int i = 0; i < 256; i++) begin
        mval[k][i] = 0; mmem[k][i] = 16'h0;
      end
    end
    set_idle();
    reset = 1; rd = 0; wr = 0; addr = 8'h00; tdata = 16'h0; tdrv = 0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_busy%0d", k), busy_w[k], 0);
      check($sformatf("rst_ready%0d", k), ready_w[k], 0);
      check($sformatf("rst_err%0d", k), err_w[k], 0);
      check($sformatf("rst_busz%0d", k), busz[k], 1);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk_en = 1;

    // write then read back
    run_txn(OP_WR, 8'h12, 16'hBEEF, 5, 1);
    run_txn(OP_RD, 8'h12, 16'h0000, 5, 1);
    for (int k = 0; k < N; k++) begin
      check($sformatf("beef_rd%0d", k), last_rd[k], 16'hBEEF);
      check($sformatf("beef_rcnt%0d", k), ready_cnt[k], 1);
    end
    check("lat_ws0", ready_cyc[0], 0);
    check("lat_ws2", ready_cyc[1], 2);
    check("lat_ws3", ready_cyc[2], 3);

    // rd held 10 cycles: exactly one ready
    run_txn(OP_RD, 8'h00, 16'h0000, 10, 2);
    check("hold_rcnt_ws3", ready_cnt[2], 1);
    check("hold_rcyc_ws3", ready_cyc[2], 3);

    // abort: short write is lost where wait states outlast the request
    run_txn(OP_WR, 8'h05, 16'h5555, 5, 1);
    run_txn(OP_WR, 8'h05, 16'h1234, 2, 1);
    check("abort_rcnt0", ready_cnt[0], 1);
    check("abort_rcnt1", ready_cnt[1], 0);
    check("abort_rcnt2", ready_cnt[2], 0);
    run_txn(OP_RD, 8'h05, 16'h0000, 5, 1);
    check("abort_rd0", last_rd[0], 16'h1234);
    check("abort_rd1", last_rd[1], 16'h5555);
    check("abort_rd2", last_rd[2], 16'h5555);

    // rd and wr together: write wins, err pulses once
    run_txn(OP_BOTH, 8'h07, 16'h00AA, 5, 1);
    for (int k = 0; k < N; k++) check($sformatf("both_err%0d", k), err_cnt[k], 1);
    run_txn(OP_RD, 8'h07, 16'h0000, 5, 1);
    for (int k = 0; k < N; k++) check($sformatf("both_rd%0d", k), last_rd[k], 16'h00AA);

    // out-of-range read on the 128-word instance
    run_txn(OP_RD, 8'h90, 16'h0000, 4, 1);
    check("oor_rd2", last_rd[2], 16'h0000);
    check("oor_err2", err_cnt[2], 1);
    check("oor_rcnt2", ready_cnt[2], 1);
    check("oor_err0", err_cnt[0], 0);

    // reset while WS=2 instance is mid-WAIT
    chk_en = 0;
    @(posedge clk); #1;
    rd = 1; wr = 0; addr = 8'h12; tdrv = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("midrst_busy%0d", k), busy_w[k], 0);
      check($sformatf("midrst_ready%0d", k), ready_w[k], 0);
      check($sformatf("midrst_busz%0d", k), busz[k], 1);
    end
    rd = 0;
    @(posedge clk); #1;
    reset = 0;
    set_idle();
    @(negedge clk); #1;
    chk_en = 1;
    run_txn(OP_RD, 8'h12, 16'h0000, 5, 1);
    check("post_rst_rd1", last_rd[1], 16'hBEEF);
    check("post_rst_rcnt1", ready_cnt[1], 1);

    // randomized handshakes
    for (int t = 0; t < 200; t++) begin
      int op, r;
      logic [7:0] a;
      r  = int'($urandom_range(0, 99));
      op = (r < 45) ? OP_RD : (r < 90) ? OP_WR : OP_BOTH;
      a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      run_txn(op, a, 16'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, 3)));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
